reg_file: RTL and testbench
===========================

// Module: reg_file
// PURPOSE
//  Architectural register file with rename tags; the receiving end of the ROB commit port.
//  Decoder marks rd busy with its ROB tag at issue; ROB commit writes value and frees the tag.
//  Serves decoder operand lookups (value, busy, producing tag) for rs1/rs2; flushes tags on clr.
// PARAMETERS
//  REG_NUM  32  number of architectural registers (x0 hardwired zero)
//  DATA_W   32  register data width (`DATA_TYPE)
//  TAG_W    5   ROB tag width (`ROB_WRAP_POS_TYPE); MSB=1 marks a valid tag, low bits = ROB index
// PORTS
//  clk                input   1       clock, rising edge
//  rst_n              input   1       asynchronous reset, active low
//  rdy                input   1       global ready; 0 freezes all state
//  clr                input   1       mispredict flush from ROB
//  issue_enable       input   1       decoder issues an instruction writing issue_rd
//  issue_rd           input   5       destination register of issued instruction
//  issue_rob_pos      input   TAG_W   ROB tag assigned to issued instruction
//  reg_commit_enable  input   1       ROB commits a register write
//  reg_pos            input   5       committed destination register
//  reg_val            input   DATA_W  committed value
//  commit_rob_pos     input   TAG_W   tag of committing ROB entry
//  rs1_pos, rs2_pos   input   5       decoder source register indices
//  rs1_val, rs2_val   output  DATA_W  source values (combinational)
//  rs1_busy, rs2_busy output  1       1 = value pending in ROB (combinational)
//  rs1_tag, rs2_tag   output  TAG_W   producing ROB tag when busy, else 0 (combinational)
// BEHAVIOUR
//  - State per reg: val[DATA_W], busy, tag[TAG_W]. Async reset (rst_n=0): all val/busy/tag = 0.
//  - rdy=0: no state update; read outputs still reflect current state.
//  - Commit (posedge, rdy=1, reg_commit_enable=1, reg_pos!=0): val[reg_pos] <= reg_val;
//    busy[reg_pos] <= 0 and tag <= 0 only if tag[reg_pos]==commit_rob_pos (newer renames keep busy).
//  - Issue (issue_enable=1, issue_rd!=0): busy[issue_rd] <= 1, tag[issue_rd] <= issue_rob_pos.
//  - Same cycle issue and commit to same reg: value written, issue's busy/tag win.
//  - clr=1 (rdy=1): all busy/tag cleared; same-cycle issue ignored; same-cycle commit value still written.
//  - x0: writes and issues ignored; reads always val=0, busy=0, tag=0.
//  - Read latency 0: outputs are combinational from rsN_pos and state.
//  - Tag compare uses full TAG_W incl. valid MSB; committed tag from ROB always has MSB=1.
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: reads forward same-cycle commit: if reg_commit_enable, rdy,
//    reg_pos==rsN_pos!=0 and tag[rsN_pos]==commit_rob_pos -> rsN_val=reg_val, busy=0, tag=0.
//  Undefined: reads show registered state only; decoder resolves via ROB rsN_ready query.
// STRUCTURE
//  Shared `definition.v`: `REG_POS_TYPE, `DATA_TYPE, `ROB_WRAP_POS_TYPE, `REG_SIZE, `TRUE/`FALSE.
//  One sub-module reg_file_read_port (lookup + optional bypass mux), instantiated for rs1 and rs2.
// TESTING
//  1 Reset: rst_n=0 mid-run -> all rsN outputs 0 immediately, no clock needed.
//  2 Issue x5 tag 5'h13, then commit x5 tag 5'h13 val 0xDEAD -> x5 val 0xDEAD, busy=0.
//  3 Rename: issue x5 tag 5'h11, issue x5 tag 5'h12, commit tag 5'h11 val 7 -> val 7, busy=1, tag 5'h12.
//  4 Same-cycle issue x3 tag 5'h14 + commit x3 tag 5'h10 val 9 -> val 9, busy=1, tag 5'h14.
//  5 x0: issue/commit to x0 val 0xFFFF -> rs1_pos=0 reads val 0, busy 0.
//  6 clr with x1..x4 busy + same-cycle issue x6 -> all busy=0; x6 not busy; with BYPASS_EN,
//    read x7 during commit x7 val 42 matching tag -> rs1_val=42, busy=0 same cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and sizes for the architectural register file and its rename-tag bookkeeping.
// Optional REG_FILE_BYPASS_EN forwards same-cycle commits to the read ports.
package reg_file_pkg;

  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned TAG_W     = 5;
  localparam int unsigned REG_POS_W = $clog2(REG_NUM);

  typedef logic [DATA_W-1:0]    data_t;
  typedef logic [TAG_W-1:0]     tag_t;
  typedef logic [REG_POS_W-1:0] reg_pos_t;

endpackage

// File: rtl/reg_file_if.sv
// Decoder/ROB-facing bus of the register file: issue, commit and two operand lookups.
// The master side drives requests; the register file is the slave.
interface reg_file_if;
  import reg_file_pkg::*;

  logic     rdy;
  logic     clr;
  logic     issue_enable;
  reg_pos_t issue_rd;
  tag_t     issue_rob_pos;
  logic     reg_commit_enable;
  reg_pos_t reg_pos;
  data_t    reg_val;
  tag_t     commit_rob_pos;
  reg_pos_t rs1_pos;
  reg_pos_t rs2_pos;
  data_t    rs1_val;
  data_t    rs2_val;
  logic     rs1_busy;
  logic     rs2_busy;
  tag_t     rs1_tag;
  tag_t     rs2_tag;

  modport master (
    output rdy, clr, issue_enable, issue_rd, issue_rob_pos,
    output reg_commit_enable, reg_pos, reg_val, commit_rob_pos,
    output rs1_pos, rs2_pos,
    input  rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy, clr, issue_enable, issue_rd, issue_rob_pos,
    input  reg_commit_enable, reg_pos, reg_val, commit_rob_pos,
    input  rs1_pos, rs2_pos,
    output rs1_val, rs2_val, rs1_busy, rs2_busy, rs1_tag, rs2_tag
  );

endinterface

// File: rtl/reg_file_read_port.sv
// One combinational operand lookup: value, busy flag and producing tag for a source register.
// With REG_FILE_BYPASS_EN a matching same-cycle commit is forwarded as a resolved value.
module reg_file_read_port
  import reg_file_pkg::*;
(
  input  data_t    state_val  [REG_NUM],
  input  logic     state_busy [REG_NUM],
  input  tag_t     state_tag  [REG_NUM],
  input  logic     commit_fwd,
  input  reg_pos_t commit_pos,
  input  data_t    commit_val,
  input  tag_t     commit_tag,
  input  reg_pos_t pos,
  output data_t    val,
  output logic     busy,
  output tag_t     tag
);

  always_comb begin
    val  = '0;
    busy = 1'b0;
    tag  = '0;
    if (pos != '0) begin
      val  = state_val[pos];
      busy = state_busy[pos];
      tag  = state_busy[pos] ? state_tag[pos] : '0;
`ifdef REG_FILE_BYPASS_EN
      // Only the commit of the newest rename resolves the operand.
      if (commit_fwd && (commit_pos == pos) && (state_tag[pos] == commit_tag)) begin
        val  = commit_val;
        busy = 1'b0;
        tag  = '0;
      end
`endif
    end
  end

`ifndef REG_FILE_BYPASS_EN
  logic unused_commit;
  assign unused_commit = ^{commit_fwd, commit_pos, commit_val, commit_tag};
`endif

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags: issue marks rd busy, ROB commit writes and frees.
// Build option REG_FILE_BYPASS_EN enables same-cycle commit forwarding on both read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  reg_file_if.slave    bus
);

  data_t val_q  [REG_NUM];
  data_t val_d  [REG_NUM];
  logic  busy_q [REG_NUM];
  logic  busy_d [REG_NUM];
  tag_t  tag_q  [REG_NUM];
  tag_t  tag_d  [REG_NUM];

  logic commit_we;
  logic commit_frees;
  logic issue_we;
  logic flush;

  assign commit_we    = bus.rdy && bus.reg_commit_enable && (bus.reg_pos != '0);
  // A newer rename of the same register keeps it busy.
  assign commit_frees = commit_we && (tag_q[bus.reg_pos] == bus.commit_rob_pos);
  assign flush        = bus.rdy && bus.clr;
  assign issue_we     = bus.rdy && !bus.clr && bus.issue_enable && (bus.issue_rd != '0);

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_we) begin
      val_d[bus.reg_pos] = bus.reg_val;
    end
    if (flush) begin
      for (int i = 0; i < REG_NUM; i++) begin
        busy_d[i] = 1'b0;
        tag_d[i]  = '0;
      end
    end else begin
      if (commit_frees) begin
        busy_d[bus.reg_pos] = 1'b0;
        tag_d[bus.reg_pos]  = '0;
      end
      // Issue after commit so a same-cycle rename wins.
      if (issue_we) begin
        busy_d[bus.issue_rd] = 1'b1;
        tag_d[bus.issue_rd]  = bus.issue_rob_pos;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= '0;
        busy_q[i] <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        val_q[i]  <= val_d[i];
        busy_q[i] <= busy_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  reg_file_read_port u_rs1 (
    .state_val  (val_q),
    .state_busy (busy_q),
    .state_tag  (tag_q),
    .commit_fwd (commit_we),
    .commit_pos (bus.reg_pos),
    .commit_val (bus.reg_val),
    .commit_tag (bus.commit_rob_pos),
    .pos        (bus.rs1_pos),
    .val        (bus.rs1_val),
    .busy       (bus.rs1_busy),
    .tag        (bus.rs1_tag)
  );

  reg_file_read_port u_rs2 (
    .state_val  (val_q),
    .state_busy (busy_q),
    .state_tag  (tag_q),
    .commit_fwd (commit_we),
    .commit_pos (bus.reg_pos),
    .commit_val (bus.reg_val),
    .commit_tag (bus.commit_rob_pos),
    .pos        (bus.rs2_pos),
    .val        (bus.rs2_val),
    .busy       (bus.rs2_busy),
    .tag        (bus.rs2_tag)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic against a
// per-register reference model; bypass expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file;
  import reg_file_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_if bus ();

  reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  data_t m_val  [REG_NUM];
  logic  m_busy [REG_NUM];
  tag_t  m_tag  [REG_NUM];

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
  endtask

  function automatic void model_read(input reg_pos_t pos, output data_t v, output logic b,
                                     output tag_t t);
    v = '0;
    b = 1'b0;
    t = '0;
    if (pos != 0) begin
      v = m_val[pos];
      b = m_busy[pos];
      t = m_tag[pos];
`ifdef REG_FILE_BYPASS_EN
      if (bus.rdy && bus.reg_commit_enable && bus.reg_pos == pos &&
          m_tag[pos] == bus.commit_rob_pos) begin
        v = bus.reg_val;
        b = 1'b0;
        t = '0;
      end
`endif
    end
  endfunction

  task automatic check_reads();
    data_t v;
    logic  b;
    tag_t  t;
    model_read(bus.rs1_pos, v, b, t);
    check("rs1_val", bus.rs1_val, v);
    check("rs1_busy", bus.rs1_busy, b);
    check("rs1_tag", bus.rs1_tag, t);
    model_read(bus.rs2_pos, v, b, t);
    check("rs2_val", bus.rs2_val, v);
    check("rs2_busy", bus.rs2_busy, b);
    check("rs2_tag", bus.rs2_tag, t);
  endtask

  // Apply one rising edge of architectural behaviour to the model.
  task automatic model_clock();
    logic frees;
    if (!bus.rdy) return;
    frees = 1'b0;
    if (bus.reg_commit_enable && bus.reg_pos != 0) begin
      frees = (m_tag[bus.reg_pos] == bus.commit_rob_pos);
      m_val[bus.reg_pos] = bus.reg_val;
    end
    if (bus.clr) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else begin
      if (frees) begin
        m_busy[bus.reg_pos] = 1'b0;
        m_tag[bus.reg_pos]  = '0;
      end
      if (bus.issue_enable && bus.issue_rd != 0) begin
        m_busy[bus.issue_rd] = 1'b1;
        m_tag[bus.issue_rd]  = bus.issue_rob_pos;
      end
    end
  endtask

  task automatic idle();
    bus.rdy               = 1'b1;
    bus.clr               = 1'b0;
    bus.issue_enable      = 1'b0;
    bus.issue_rd          = '0;
    bus.issue_rob_pos     = '0;
    bus.reg_commit_enable = 1'b0;
    bus.reg_pos           = '0;
    bus.reg_val           = '0;
    bus.commit_rob_pos    = '0;
  endtask

  task automatic issue(input reg_pos_t rd, input tag_t t);
    bus.issue_enable  = 1'b1;
    bus.issue_rd      = rd;
    bus.issue_rob_pos = t;
  endtask

  task automatic commit(input reg_pos_t rd, input tag_t t, input data_t v);
    bus.reg_commit_enable = 1'b1;
    bus.reg_pos           = rd;
    bus.commit_rob_pos    = t;
    bus.reg_val           = v;
  endtask

  // Inputs are set just after an edge; settle, compare, then advance one clock.
  task automatic step();
    #1;
    check_reads();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input reg_pos_t p1, input reg_pos_t p2);
    idle();
    bus.rs1_pos = p1;
    bus.rs2_pos = p2;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    bus.rs1_pos = 5'd5;
    bus.rs2_pos = 5'd31;
    model_reset();
    #1;
    check("reset_rs1_val", bus.rs1_val, 32'h0);
    check("reset_rs2_busy", bus.rs2_busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Issue then commit with matching tag.
    idle(); issue(5'd5, 5'h13); bus.rs1_pos = 5'd5; step();
    idle(); commit(5'd5, 5'h13, 32'hDEAD); bus.rs1_pos = 5'd5; step();
    peek(5'd5, 5'd0);
    check("t2_val", bus.rs1_val, 32'hDEAD);
    check("t2_busy", bus.rs1_busy, 1'b0);
    step();

    // Commit of an older rename leaves the newer one pending.
    idle(); issue(5'd5, 5'h11); step();
    idle(); issue(5'd5, 5'h12); step();
    idle(); commit(5'd5, 5'h11, 32'd7); bus.rs2_pos = 5'd5; step();
    peek(5'd5, 5'd5);
    check("t3_val", bus.rs1_val, 32'd7);
    check("t3_busy", bus.rs1_busy, 1'b1);
    check("t3_tag", bus.rs1_tag, 5'h12);
    step();

    // Same-cycle issue and commit to one register.
    idle(); issue(5'd3, 5'h14); commit(5'd3, 5'h10, 32'd9); step();
    peek(5'd3, 5'd0);
    check("t4_val", bus.rs1_val, 32'd9);
    check("t4_busy", bus.rs1_busy, 1'b1);
    check("t4_tag", bus.rs1_tag, 5'h14);
    step();

    // x0 ignores writes and issues.
    idle(); issue(5'd0, 5'h15); commit(5'd0, 5'h15, 32'hFFFF); bus.rs1_pos = 5'd0; step();
    peek(5'd0, 5'd0);
    check("t5_val", bus.rs1_val, 32'h0);
    check("t5_busy", bus.rs1_busy, 1'b0);
    check("t5_tag", bus.rs1_tag, 5'h0);
    step();

    // Flush clears all renames and drops the same-cycle issue.
    for (int i = 1; i <= 4; i++) begin
      idle(); issue(reg_pos_t'(i), tag_t'(5'h18 + i)); step();
    end
    idle(); bus.clr = 1'b1; issue(5'd6, 5'h1C); step();
    for (int i = 1; i <= 6; i++) begin
      peek(reg_pos_t'(i), 5'd6);
      check("t6_clr_busy", bus.rs1_busy, 1'b0);
      check("t6_x6_busy", bus.rs2_busy, 1'b0);
    end

    // Read during a matching commit.
    idle(); issue(5'd7, 5'h1D); step();
    idle(); commit(5'd7, 5'h1D, 32'd42); bus.rs1_pos = 5'd7; bus.rs2_pos = 5'd7;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("t6_byp_val", bus.rs1_val, 32'd42);
    check("t6_byp_busy", bus.rs1_busy, 1'b0);
`else
    check("t6_nobyp_val", bus.rs1_val, 32'd0);
    check("t6_nobyp_busy", bus.rs1_busy, 1'b1);
`endif
    step();

    // Random traffic, biased so commits often match the live rename.
    for (int n = 0; n < 600; n++) begin
      idle();
      bus.rdy = ($urandom_range(0, 9) != 0);
      bus.clr = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) != 0)
        issue(reg_pos_t'($urandom_range(0, 31)), tag_t'({1'b1, 4'($urandom)}));
      if ($urandom_range(0, 1) != 0) begin
        bus.reg_commit_enable = 1'b1;
        bus.reg_pos           = reg_pos_t'($urandom_range(0, 31));
        bus.reg_val           = data_t'($urandom);
        bus.commit_rob_pos    = (m_busy[bus.reg_pos] && $urandom_range(0, 2) != 0) ?
                                m_tag[bus.reg_pos] : tag_t'({1'b1, 4'($urandom)});
      end
      bus.rs1_pos = ($urandom_range(0, 2) == 0) ? bus.reg_pos
                                                : reg_pos_t'($urandom_range(0, 31));
      bus.rs2_pos = reg_pos_t'($urandom_range(0, 31));
      step();
    end

    // Asynchronous reset mid-run, between clock edges.
    peek(5'd5, 5'd3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t1_rs1_val", bus.rs1_val, 32'h0);
    check("t1_rs1_busy", bus.rs1_busy, 1'b0);
    check("t1_rs1_tag", bus.rs1_tag, 5'h0);
    check("t1_rs2_val", bus.rs2_val, 32'h0);
    check("t1_rs2_busy", bus.rs2_busy, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    peek(5'd5, 5'd3);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
